// File: rtl/video_timing_window_gen.sv
// Raster timing generator with a look-ahead pixel request for a movable window; window
// pixels are merged onto a background. Optional macro VIDEO_TIMING_COLORBAR_EN: colour bars outside the window.
module video_timing_window_gen #(
  parameter int          H_ACTIVE      = 1280,
  parameter int          H_FRONT_PORCH = 110,
  parameter int          H_SYNC_TIME   = 40,
  parameter int          H_BACK_PORCH  = 220,
  parameter int          V_ACTIVE      = 720,
  parameter int          V_FRONT_PORCH = 5,
  parameter int          V_SYNC_TIME   = 5,
  parameter int          V_BACK_PORCH  = 20,
  parameter int          H_POLARITY    = 1,
  parameter int          V_POLARITY    = 1,
  parameter int          CNT_W         = 12,
  parameter int          REQ_LEAD      = 2,
  parameter logic [23:0] BG_COLOR      = 24'h000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_win_x,
  input  logic [CNT_W-1:0] i_win_y,
  input  logic [CNT_W-1:0] i_win_w,
  input  logic [CNT_W-1:0] i_win_h,
  input  logic [23:0]      i_rgb,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [23:0]      o_rgb,
  output logic             o_data_req,
  output logic [CNT_W-1:0] o_x_pos,
  output logic [CNT_W-1:0] o_y_pos,
  output logic             o_frame_start
);

  localparam int   H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_TIME + H_BACK_PORCH;
  localparam int   V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_TIME + V_BACK_PORCH;
  localparam int   H_START = H_SYNC_TIME + H_BACK_PORCH;
  localparam int   V_START = V_SYNC_TIME + V_BACK_PORCH;
  localparam logic HS_ON   = 1'(H_POLARITY);
  localparam logic VS_ON   = 1'(V_POLARITY);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] win_x_q, win_y_q, win_w_q, win_h_q;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, req_q, req_d, fs_q, fs_d;
  logic [23:0]      rgb_q, rgb_d, bg_pix;
  logic [CNT_W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [CNT_W-1:0] x_cur, y_cur, h_la, x_la;
  logic             h_wrap, h_act, v_act, la_act, frame_top;

  // Window ends are formed one bit wider so x+w never wraps back into range.
  function automatic logic in_window(input logic [CNT_W-1:0] x, y, wx, wy, ww, wh);
    logic [CNT_W:0] x_end, y_end;
    x_end = {1'b0, wx} + {1'b0, ww};
    y_end = {1'b0, wy} + {1'b0, wh};
    return (ww != '0) && (wh != '0) && (x >= wx) && ({1'b0, x} < x_end) &&
           (y >= wy) && ({1'b0, y} < y_end);
  endfunction

`ifdef VIDEO_TIMING_COLORBAR_EN
  logic [2:0] bar_idx;
  always_comb begin
    bar_idx = 3'((int'(x_cur) * 8) / H_ACTIVE);
    case (bar_idx)
      3'd0:    bg_pix = 24'hFFFFFF;
      3'd1:    bg_pix = 24'hFFFF00;
      3'd2:    bg_pix = 24'h00FFFF;
      3'd3:    bg_pix = 24'h00FF00;
      3'd4:    bg_pix = 24'hFF00FF;
      3'd5:    bg_pix = 24'hFF0000;
      3'd6:    bg_pix = 24'h0000FF;
      default: bg_pix = 24'h000000;
    endcase
  end
`else
  assign bg_pix = BG_COLOR;
`endif

  always_comb begin
    h_wrap  = (h_cnt_q == CNT_W'(H_TOTAL - 1));
    h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);

    h_act  = (h_cnt_q >= CNT_W'(H_START)) && (h_cnt_q < CNT_W'(H_START + H_ACTIVE));
    v_act  = (v_cnt_q >= CNT_W'(V_START)) && (v_cnt_q < CNT_W'(V_START + V_ACTIVE));
    x_cur  = h_cnt_q - CNT_W'(H_START);
    y_cur  = v_cnt_q - CNT_W'(V_START);
    // Request looks REQ_LEAD+1 pixels ahead on the same line; the back porch keeps it off the line edge.
    h_la   = h_cnt_q + CNT_W'(REQ_LEAD + 1);
    la_act = (h_la >= CNT_W'(H_START)) && (h_la < CNT_W'(H_START + H_ACTIVE));
    x_la   = h_la - CNT_W'(H_START);
    frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);

    hs_d    = (h_cnt_q < CNT_W'(H_SYNC_TIME)) ? HS_ON : ~HS_ON;
    vs_d    = (v_cnt_q < CNT_W'(V_SYNC_TIME)) ? VS_ON : ~VS_ON;
    de_d    = h_act && v_act;
    fs_d    = frame_top;
    req_d   = la_act && v_act && in_window(x_la, y_cur, win_x_q, win_y_q, win_w_q, win_h_q);
    x_pos_d = de_d ? x_cur : x_pos_q;
    y_pos_d = de_d ? y_cur : y_pos_q;

    rgb_d = '0;
    if (de_d) begin
      if (in_window(x_cur, y_cur, win_x_q, win_y_q, win_w_q, win_h_q)) rgb_d = i_rgb;
      else rgb_d = bg_pix;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      win_x_q <= '0;
      win_y_q <= '0;
      win_w_q <= '0;
      win_h_q <= '0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      de_q    <= 1'b0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      x_pos_q <= '0;
      y_pos_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (frame_top) begin
        win_x_q <= i_win_x;
        win_y_q <= i_win_y;
        win_w_q <= i_win_w;
        win_h_q <= i_win_h;
      end
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      req_q   <= req_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
      x_pos_q <= x_pos_d;
      y_pos_q <= y_pos_d;
    end
  end

  assign o_hs          = hs_q;
  assign o_vs          = vs_q;
  assign o_de          = de_q;
  assign o_data_req    = req_q;
  assign o_frame_start = fs_q;
  assign o_rgb         = rgb_q;
  assign o_x_pos       = x_pos_q;
  assign o_y_pos       = y_pos_q;

endmodule

// File: tb/tb_video_timing_window_gen.sv
// Directed bench for video_timing_window_gen on a small 25x14 raster with REQ_LEAD=2.
module tb_video_timing_window_gen;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 3;
  localparam int HT = 25, VT = 14, FRAME = 350, LEAD = 2, W = 12;
  localparam logic [23:0] BG = 24'h203040;
  localparam logic [23:0] IDLE_RGB = 24'hABCDEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  win_x = '0, win_y = '0, win_w = '0, win_h = '0;
  logic [23:0]   rgb_in = '0;
  logic          hs, vs, de, req, fs;
  logic [23:0]   rgb_out;
  logic [W-1:0]  x_pos, y_pos;

  int tests_run = 0;
  int tests_failed = 0;

  // Bench raster model: pos counts output cycles from the frame_start cycle.
  int pos;
  int tag_pipe[2];
  int req_seen, exp_tag;
  int bw_x, bw_y, bw_w, bw_h;
  logic e_hs, e_vs, e_de, e_fs, e_req, e_in;
  logic [23:0] e_rgb;
  int e_x, e_y;

  video_timing_window_gen #(
    .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC_TIME(HS), .H_BACK_PORCH(HBP),
    .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC_TIME(VS), .V_BACK_PORCH(VBP),
    .H_POLARITY(1), .V_POLARITY(1), .CNT_W(W), .REQ_LEAD(LEAD), .BG_COLOR(BG)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_win_x(win_x), .i_win_y(win_y), .i_win_w(win_w), .i_win_h(win_h),
    .i_rgb(rgb_in),
    .o_hs(hs), .o_vs(vs), .o_de(de), .o_rgb(rgb_out), .o_data_req(req),
    .o_x_pos(x_pos), .o_y_pos(y_pos), .o_frame_start(fs)
  );

  always #5 clk = ~clk;

  function automatic bit pix_de(int p);
    int h = p % HT;
    int v = p / HT;
    return (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
  endfunction

  function automatic bit pix_in(int p);
    int x = p % HT - (HS + HBP);
    int y = p / HT - (VS + VBP);
    return pix_de(p) && (bw_w != 0) && (bw_h != 0) && (x >= bw_x) && (x < bw_x + bw_w) &&
           (y >= bw_y) && (y < bw_y + bw_h);
  endfunction

  function automatic logic [23:0] bg_color(int x);
`ifdef VIDEO_TIMING_COLORBAR_EN
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[(x * 8 / HA) % 8];
`else
    return (x >= 0) ? BG : BG;
`endif
  endfunction

  task automatic model_reset();
    pos = -1;
    tag_pipe = '{-1, -1};
    req_seen = 0;
    exp_tag = 0;
    e_x = 0;
    e_y = 0;
  endtask

  // Advance one cycle: answer requests LEAD cycles late with their sequence number, update expectations.
  task automatic step();
    int cur;
    @(negedge clk);
    cur = req ? req_seen : -1;
    if (req) req_seen++;
    rgb_in = (tag_pipe[1] >= 0) ? 24'(tag_pipe[1]) : IDLE_RGB;
    tag_pipe[1] = tag_pipe[0];
    tag_pipe[0] = cur;
    pos = (pos + 1) % FRAME;
    if (pos == 0) begin
      bw_x = int'(win_x); bw_y = int'(win_y); bw_w = int'(win_w); bw_h = int'(win_h);
    end
    e_fs  = (pos == 0);
    e_hs  = (pos % HT) < HS;
    e_vs  = (pos / HT) < VS;
    e_de  = pix_de(pos);
    e_in  = pix_in(pos);
    e_req = pix_in((pos + LEAD + 1) % FRAME);
    if (e_de) begin
      e_x = pos % HT - (HS + HBP);
      e_y = pos / HT - (VS + VBP);
    end
    if (!e_de) e_rgb = '0;
    else if (e_in) begin e_rgb = 24'(exp_tag); exp_tag++; end
    else e_rgb = bg_color(e_x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_window(int x, int y, int w, int h);
    win_x = W'(x); win_y = W'(y); win_w = W'(w); win_h = W'(h);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++; if ({hs, vs, de, req, fs} !== 5'b00000) begin tests_failed++; $display("FAIL reset_ctrl got=%b exp=00000", {hs, vs, de, req, fs}); end
    tests_run++; if ({rgb_out, x_pos, y_pos} !== '0) begin tests_failed++; $display("FAIL reset_data got rgb=%h x=%0d y=%0d exp 0", rgb_out, x_pos, y_pos); end
    repeat (2) @(negedge clk);
    tests_run++; if ({hs, vs, de, req, fs} !== 5'b00000) begin tests_failed++; $display("FAIL reset_held got=%b exp=00000", {hs, vs, de, req, fs}); end
  endtask

  task automatic test_window_disabled();
    int de_cnt = 0, req_cnt = 0, fs_cnt = 0;
    set_window(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      de_cnt += int'(de); req_cnt += int'(req); fs_cnt += int'(fs);
      tests_run++; if ({hs, vs, de, fs, req} !== {e_hs, e_vs, e_de, e_fs, 1'b0}) begin tests_failed++; $display("FAIL dis_ctrl pos=%0d got=%b exp=%b", pos, {hs, vs, de, fs, req}, {e_hs, e_vs, e_de, e_fs, 1'b0}); end
      tests_run++; if (rgb_out !== e_rgb) begin tests_failed++; $display("FAIL dis_rgb pos=%0d got=%h exp=%h", pos, rgb_out, e_rgb); end
      tests_run++; if (x_pos !== W'(e_x) || y_pos !== W'(e_y)) begin tests_failed++; $display("FAIL dis_xy pos=%0d got=%0d,%0d exp=%0d,%0d", pos, x_pos, y_pos, e_x, e_y); end
    end
    tests_run++; if (de_cnt != 2 * HA * VA) begin tests_failed++; $display("FAIL dis_de_count got=%0d exp=%0d", de_cnt, 2 * HA * VA); end
    tests_run++; if (req_cnt != 0) begin tests_failed++; $display("FAIL dis_req_count got=%0d exp=0", req_cnt); end
    tests_run++; if (fs_cnt != 2) begin tests_failed++; $display("FAIL dis_fs_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_window();
    int req_cnt = 0;
    set_window(4, 2, 6, 3);
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      req_cnt += int'(req);
      tests_run++; if (req !== e_req) begin tests_failed++; $display("FAIL win_req pos=%0d got=%b exp=%b", pos, req, e_req); end
      tests_run++; if (rgb_out !== e_rgb || de !== e_de) begin tests_failed++; $display("FAIL win_rgb pos=%0d got=%h/%b exp=%h/%b", pos, rgb_out, de, e_rgb, e_de); end
    end
    tests_run++; if (req_cnt != 36) begin tests_failed++; $display("FAIL win_req_count got=%0d exp=36", req_cnt); end
  endtask

  task automatic test_clipping();
    int req_cnt = 0;
    set_window(12, 6, 10, 5);
    do_reset();
    for (int i = 0; i < FRAME; i++) begin
      step();
      req_cnt += int'(req);
      tests_run++; if (req !== e_req) begin tests_failed++; $display("FAIL clip_req pos=%0d got=%b exp=%b", pos, req, e_req); end
      tests_run++; if (rgb_out !== e_rgb) begin tests_failed++; $display("FAIL clip_rgb pos=%0d got=%h exp=%h", pos, rgb_out, e_rgb); end
    end
    tests_run++; if (req_cnt != 8) begin tests_failed++; $display("FAIL clip_req_count got=%0d exp=8", req_cnt); end
  endtask

  task automatic test_mid_frame_change();
    int req_cnt[2] = '{0, 0};
    set_window(4, 2, 6, 3);
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      req_cnt[i / FRAME] += int'(req);
      if (i == 100) win_x = W'(8);
      tests_run++; if (req !== e_req) begin tests_failed++; $display("FAIL mid_req pos=%0d got=%b exp=%b", pos, req, e_req); end
      tests_run++; if (rgb_out !== e_rgb) begin tests_failed++; $display("FAIL mid_rgb pos=%0d got=%h exp=%h", pos, rgb_out, e_rgb); end
    end
    tests_run++; if (req_cnt[0] != 18 || req_cnt[1] != 18) begin tests_failed++; $display("FAIL mid_req_count got=%0d,%0d exp=18,18", req_cnt[0], req_cnt[1]); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    set_window(0, 0, 0, 0);
    do_reset();
    repeat (5 * HT + 10) step();
    tests_run++; if (de !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_de got=%b exp=1", de); end
    rst = 1'b1;
    #1;
    tests_run++; if ({hs, vs, de, req, fs} !== 5'b00000) begin tests_failed++; $display("FAIL areset_ctrl got=%b exp=00000", {hs, vs, de, req, fs}); end
    tests_run++; if ({rgb_out, x_pos, y_pos} !== '0) begin tests_failed++; $display("FAIL areset_data got rgb=%h x=%0d y=%0d exp 0", rgb_out, x_pos, y_pos); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();
    tests_run++; if ({fs, hs, vs, de} !== 4'b1110) begin tests_failed++; $display("FAIL areset_first got=%b exp=1110", {fs, hs, vs, de}); end
    do begin
      step();
      n++;
    end while (!fs && n < 400);
    tests_run++; if (n != FRAME) begin tests_failed++; $display("FAIL areset_period got=%0d exp=%0d", n, FRAME); end
  endtask

`ifdef VIDEO_TIMING_COLORBAR_EN
  task automatic test_colorbar();
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    set_window(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (e_de) begin
        tests_run++; if (rgb_out !== bars[e_x / 2]) begin tests_failed++; $display("FAIL bar_rgb x=%0d got=%h exp=%h", e_x, rgb_out, bars[e_x / 2]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_window_disabled();
    test_window();
    test_clipping();
    test_mid_frame_change();
    test_async_reset();
`ifdef VIDEO_TIMING_COLORBAR_EN
    test_colorbar();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
